// File: rtl/tate_pairing_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tate_pairing_host_if
// Brief    : Operand input stream and result output stream of the pairing host.
// Revision : 1.0  initial release
// ============================================================================
interface tate_pairing_host_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  // The host block is the slave: it sinks operands and sources results.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface
`default_nettype wire

// File: rtl/tate_pairing_host.sv
`default_nettype none
// ============================================================================
// Module   : tate_pairing_host
// Brief    : Loads x1,y1,x2,y2 from a word stream, starts the tate_pairing core
//            with a core_rst pulse, waits for done and streams the result back.
//            Optional WAIT watchdog enabled by defining TATE_HOST_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tate_pairing_host #(
  parameter int M              = 97,
  parameter int DW             = 32,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  wire logic            clk,
  input  wire logic            reset,
  tate_pairing_host_if.slave   bus,
  output logic                 busy,
  output logic                 err,
  output logic                 core_rst,
  output logic [2*M-1:0]       core_x1,
  output logic [2*M-1:0]       core_y1,
  output logic [2*M-1:0]       core_x2,
  output logic [2*M-1:0]       core_y2,
  input  wire logic            core_done,
  input  wire logic [12*M-1:0] core_out
);

  localparam int EW     = 2 * M;
  localparam int RW     = 12 * M;
  localparam int NW_IN  = (EW + DW - 1) / DW;
  localparam int NW_OUT = (RW + DW - 1) / DW;
  localparam int SW     = 4 * EW;
  localparam int RPW    = NW_OUT * DW;
  localparam int WCW    = $clog2(NW_IN + 1);
  localparam int OCW    = $clog2(NW_OUT + 1);
  localparam int SCW    = $clog2(START_CYCLES + 1);

  localparam logic [WCW-1:0] c_word_last  = WCW'(NW_IN - 1);
  localparam logic [OCW-1:0] c_out_last   = OCW'(NW_OUT - 1);
  localparam logic [SCW-1:0] c_start_last = SCW'(START_CYCLES - 1);
  localparam logic [SW-1:0]  c_elem_mask  = SW'({EW{1'b1}});
  localparam logic [SW-1:0]  c_word_mask  = SW'({DW{1'b1}});

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_elem;
  logic [WCW-1:0]   r_word;
  logic [SCW-1:0]   r_start_cnt;
  logic [OCW-1:0]   r_out_cnt;
  logic [SW-1:0]    r_stage;
  logic [RW-1:0]    r_result;
  logic [EW-1:0]    r_core_x1, r_core_y1, r_core_x2, r_core_y2;
  logic             r_core_rst;

  logic             w_in_fire;
  logic             w_in_done;
  logic             w_out_fire;
  logic             w_out_end;
  logic             w_timeout;
  logic             w_to_hit;
  int               w_pos;
  logic [SW-1:0]    w_wmask;
  logic [SW-1:0]    w_stage_nxt;
  logic [RPW-1:0]   w_result_pad;

  assign w_in_fire  = (r_state == S_LOAD) && bus.in_valid;
  assign w_in_done  = w_in_fire && (r_elem == 2'd3) && (r_word == c_word_last);
  assign w_out_end  = (r_out_cnt == c_out_last);
  assign w_out_fire = (r_state == S_DRAIN) && bus.out_ready;

  // Masking to the element window drops the final word's bits above 2M.
  assign w_pos       = int'(r_elem) * EW + int'(r_word) * DW;
  assign w_wmask     = (c_word_mask << w_pos) & (c_elem_mask << (int'(r_elem) * EW));
  assign w_stage_nxt = (r_stage & ~w_wmask) | ((SW'(bus.in_data) << w_pos) & w_wmask);

  assign w_result_pad = RPW'(r_result);
  assign bus.out_data = (r_state == S_DRAIN) ? w_result_pad[int'(r_out_cnt) * DW +: DW] : '0;

  assign core_rst = r_core_rst;
  assign core_x1  = r_core_x1;
  assign core_y1  = r_core_y1;
  assign core_x2  = r_core_x2;
  assign core_y2  = r_core_y2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout     = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (w_in_done) w_state_nxt = S_START;
      end
      S_START: begin
        busy = 1'b1;
        if (r_start_cnt == c_start_last) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (core_done) begin
          w_state_nxt = S_DRAIN;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = w_out_end;
        if (bus.out_ready && w_out_end) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // core_rst is registered so it is glitch-free and high for whole START cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_rst <= 1'b1;
    end else begin
      r_core_rst <= (w_state_nxt == S_START) || w_timeout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_elem    <= 2'd0;
      r_word    <= '0;
      r_stage   <= '0;
      r_core_x1 <= '0;
      r_core_y1 <= '0;
      r_core_x2 <= '0;
      r_core_y2 <= '0;
    end else if (w_in_fire) begin
      r_stage <= w_stage_nxt;
      if (r_word == c_word_last) begin
        r_word <= '0;
        r_elem <= r_elem + 2'd1;
      end else begin
        r_word <= r_word + WCW'(1);
      end
      // Operands change only when a complete set has arrived.
      if (w_in_done) begin
        r_core_x1 <= w_stage_nxt[0*EW +: EW];
        r_core_y1 <= w_stage_nxt[1*EW +: EW];
        r_core_x2 <= w_stage_nxt[2*EW +: EW];
        r_core_y2 <= w_stage_nxt[3*EW +: EW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_cnt <= '0;
    end else if (r_state == S_START) begin
      r_start_cnt <= r_start_cnt + SCW'(1);
    end else begin
      r_start_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result  <= '0;
      r_out_cnt <= '0;
    end else begin
      if ((r_state == S_WAIT) && core_done) r_result <= core_out;
      if (w_out_fire) r_out_cnt <= w_out_end ? '0 : r_out_cnt + OCW'(1);
    end
  end

`ifdef TATE_HOST_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] c_to_last = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] r_to_cnt;
  logic           r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + TCW'(1) : '0;
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if ((r_state == S_LOAD) && (w_state_nxt == S_START)) begin
        r_err <= 1'b0;
      end
    end
  end

  assign w_to_hit = (r_to_cnt == c_to_last);
  assign err      = r_err;
`else
  assign w_to_hit = 1'b0;
  assign err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tate_pairing_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_tate_pairing_host
// Brief    : Directed bench for tate_pairing_host with a fixed-latency core stub.
// Revision : 1.0  initial release
// ============================================================================
module tb_tate_pairing_host;
  localparam int M = 97, DW = 32, EW = 194, RW = 1164, NW_IN = 7, NW_OUT = 37;
  localparam int LAT = 100, TO = 50, START = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tate_pairing_host_if #(.DW(DW)) bus();

  logic            busy, err, core_rst, core_done;
  logic [EW-1:0]   core_x1, core_y1, core_x2, core_y2;
  logic [RW-1:0]   core_out;
  logic            stub_en;
  int              stub_cnt;
  int              checks = 0;
  int              errors = 0;
  time             in_xfer_t, job_first_t, last_out_t;

  tate_pairing_host #(.M(M), .DW(DW), .START_CYCLES(START), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err(err), .core_rst(core_rst),
    .core_x1(core_x1), .core_y1(core_y1), .core_x2(core_x2), .core_y2(core_y2),
    .core_done(core_done), .core_out(core_out)
  );

  // Core stub: done rises LAT cycles after core_rst releases, held until next core_rst.
  always @(posedge clk) begin
    if (core_rst) begin
      stub_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_en && stub_cnt == LAT - 1) core_done <= 1'b1;
    end
  end

  function automatic logic [RW-1:0] pat(input int seed);
    logic [RW-1:0] v;
    logic [7:0]    by;
    for (int b = 0; b < RW; b++) begin
      by   = 8'((b / 8 + seed) % 256);
      v[b] = by[b % 8];
    end
    return v;
  endfunction

  task automatic push_word(input logic [31:0] w, input bit gap);
    int t;
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL push_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    in_xfer_t = $time;
  endtask

  task automatic send_job(input logic [3:0][223:0] ops, input bit gap);
    for (int e = 0; e < 4; e++) begin
      for (int j = 0; j < NW_IN; j++) begin
        push_word(ops[e][j*32 +: 32], gap);
        if (e == 0 && j == 0) job_first_t = in_xfer_t;
      end
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_ops(input logic [3:0][223:0] ops);
    checks++;
    if (core_x1 !== ops[0][EW-1:0]) begin errors++; $display("FAIL core_x1 got %h exp %h", core_x1, ops[0][EW-1:0]); end
    checks++;
    if (core_y1 !== ops[1][EW-1:0]) begin errors++; $display("FAIL core_y1 got %h exp %h", core_y1, ops[1][EW-1:0]); end
    checks++;
    if (core_x2 !== ops[2][EW-1:0]) begin errors++; $display("FAIL core_x2 got %h exp %h", core_x2, ops[2][EW-1:0]); end
    checks++;
    if (core_y2 !== ops[3][EW-1:0]) begin errors++; $display("FAIL core_y2 got %h exp %h", core_y2, ops[3][EW-1:0]); end
  endtask

  task automatic wait_valid(input time t0, input int exp_lat);
    int n, lat;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout got %b exp 1", bus.out_valid);
    end
    lat = int'(($time - t0) / 10);
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL latency got %0d exp %0d", lat, exp_lat); end
    end
  endtask

  task automatic drain(input logic [RW-1:0] res, input int mode, output logic [31:0] last_word);
    logic [NW_OUT*DW-1:0] p;
    int k, cyc;
    bit rdy;
    p = {20'b0, res};
    k = 0;
    cyc = 0;
    last_word = '0;
    while (k < NW_OUT && cyc < 400) begin
      @(negedge clk);
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      bus.out_ready = rdy;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== p[k*32 +: 32]) begin
        errors++;
        $display("FAIL out_word%0d got %b/%h exp 1/%h", k, bus.out_valid, bus.out_data, p[k*32 +: 32]);
      end
      checks++;
      if (bus.out_last !== (k == NW_OUT - 1)) begin
        errors++;
        $display("FAIL out_last%0d got %b exp %b", k, bus.out_last, (k == NW_OUT - 1));
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_drain got %b exp 0", bus.in_ready); end
      if (rdy && bus.out_valid === 1'b1) begin
        last_word = bus.out_data;
        k++;
        if (k == NW_OUT) last_out_t = $time;
      end
      cyc++;
    end
    checks++;
    if (k != NW_OUT) begin errors++; $display("FAIL drain_count got %0d exp %0d", k, NW_OUT); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_drain valid/ready got %b/%b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst got %b exp 1", core_rst); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_out got %b/%b/%h exp 0/0/0", bus.out_valid, bus.out_last, bus.out_data);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_busy_err got %b/%b exp 0/0", busy, err); end
    checks++;
    if (core_x1 !== '0 || core_y2 !== '0) begin errors++; $display("FAIL rst_ops got %h/%h exp 0/0", core_x1, core_y2); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (core_rst !== 1'b0) begin errors++; $display("FAIL rst_release_core_rst got %b exp 0", core_rst); end
  endtask

  task automatic test_load_start();
    logic [3:0][223:0] ops;
    int n;
    ops = {224'd4, 224'd3, 224'd2, 224'd1};
    core_out = pat(0);
    send_job(ops, 1'b0);
    check_ops(ops);
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_ready got %b/%b exp 1/0", busy, bus.in_ready);
    end
    n = 0;
    while (core_rst === 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n != START) begin errors++; $display("FAIL core_rst_width got %0d exp %0d", n, START); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b exp 1", busy); end
  endtask

  task automatic test_drain();
    logic [31:0] lw;
    wait_valid(in_xfer_t, START + LAT + 1);
    checks++;
    if (bus.out_data !== 32'h03020100) begin errors++; $display("FAIL word0 got %h exp 03020100", bus.out_data); end
    drain(pat(0), 0, lw);
    checks++;
    if (lw !== 32'h00000190) begin errors++; $display("FAIL word36 got %h exp 00000190", lw); end
  endtask

  task automatic test_backpressure();
    logic [3:0][223:0] ops;
    logic [31:0] lw;
    ops[0] = {30'h3fffffff, 194'(64'hdeadbeef_01234567)};
    ops[1] = {30'h15555555, 2'b11, 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978};
    ops[2] = {30'h0, 194'd5};
    ops[3] = {30'h2aaaaaaa, 2'b10, 192'd0};
    core_out = pat(7);
    send_job(ops, 1'b0);
    check_ops(ops);
    wait_valid(in_xfer_t, START + LAT + 1);
    drain(pat(7), 1, lw);
  endtask

  task automatic test_reset_midop();
    logic [3:0][223:0] ops;
    logic [31:0] lw;
    ops = {224'd40, 224'd30, 224'd20, 224'd10};
    core_out = pat(20);
    send_job(ops, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset valid/core_rst/busy got %b/%b/%b exp 0/1/0", bus.out_valid, core_rst, busy);
    end
    checks++;
    if (core_x1 !== '0) begin errors++; $display("FAIL midwait_ops got %h exp 0", core_x1); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midwait_in_ready got %b exp 1", bus.in_ready); end
    for (int i = 0; i < 10; i++) push_word(32'h5a5a0000 + i, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (core_rst !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset core_rst/valid got %b/%b exp 1/0", core_rst, bus.out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midload_in_ready got %b exp 1", bus.in_ready); end
    ops = {224'h77, 224'h66, 224'h55, 224'h44};
    core_out = pat(33);
    send_job(ops, 1'b0);
    check_ops(ops);
    wait_valid(in_xfer_t, START + LAT + 1);
    drain(pat(33), 0, lw);
  endtask

  task automatic test_timeout();
    logic [3:0][223:0] ops;
    logic [31:0] lw;
    int n, vseen;
    ops = {224'd9, 224'd8, 224'd7, 224'd6};
`ifdef TATE_HOST_TIMEOUT_EN
    stub_en = 1'b0;
    send_job(ops, 1'b0);
    n = 1;
    vseen = 0;
    while (err !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid === 1'b1) vseen++;
    end
    n--;
    checks++;
    if (n != START + TO) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", n, START + TO); end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL timeout_out_valid got %0d exp 0", vseen); end
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL timeout_state ready/busy/core_rst got %b/%b/%b exp 1/0/1", bus.in_ready, busy, core_rst);
    end
    @(posedge clk);
    #1;
    checks++;
    if (core_rst !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after core_rst/err got %b/%b exp 0/1", core_rst, err);
    end
    stub_en = 1'b1;
    ops = {224'd13, 224'd12, 224'd11, 224'd10};
    core_out = pat(61);
    send_job(ops, 1'b0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    check_ops(ops);
    wait_valid(in_xfer_t, START + LAT + 1);
    drain(pat(61), 0, lw);
`else
    core_out = pat(61);
    send_job(ops, 1'b0);
    wait_valid(in_xfer_t, START + LAT + 1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_tied got %b exp 0", err); end
    drain(pat(61), 0, lw);
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0][223:0] opa, opb;
    logic [31:0] lw;
    time t1;
    opa = {224'hd, 224'hc, 224'hb, 224'ha};
    opb = {224'h1d, 224'h1c, 224'h1b, 224'h1a};
    core_out = pat(50);
    send_job(opa, 1'b1);
    check_ops(opa);
    t1 = in_xfer_t;
    fork
      begin
        wait_valid(t1, START + LAT + 1);
        drain(pat(50), 0, lw);
      end
      begin
        send_job(opb, 1'b0);
      end
    join
    checks++;
    if (job_first_t <= last_out_t + 5) begin
      errors++;
      $display("FAIL job2_accept_time got %0t exp after %0t", job_first_t, last_out_t + 5);
    end
    check_ops(opb);
    core_out = pat(90);
    wait_valid(in_xfer_t, START + LAT + 1);
    drain(pat(90), 0, lw);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    stub_en       = 1'b1;
    core_out      = '0;
    test_reset();
    test_load_start();
    test_drain();
    test_backpressure();
    test_reset_midop();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout time=%0t limit=1000000", $time);
    $fatal(1, "bench time limit");
  end
endmodule
`default_nettype wire
